// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller.
// Supplies a default for the WIDTH macro when the build does not define one.
`ifndef WIDTH
`define WIDTH 2
`endif

package btb_pkg;

    localparam int BTB_SIZE = 256;
    localparam int IDX_W    = 8;
    localparam int TAG_W    = 10;
    localparam int TGT_W    = 12;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [TGT_W-1:0] target;
        logic             uncond;
        logic             mispredict;
    } btb_upd_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } btb_state_t;

    function automatic btb_upd_t make_upd(input logic [31:0] pc, input logic [31:0] target,
                                          input logic uncond, input logic mispredict);
        btb_upd_t u;
        u.idx        = pc[9:2];
        u.tag        = pc[19:10];
        u.target     = target[13:2];
        u.uncond     = uncond;
        u.mispredict = mispredict;
        return u;
    endfunction

    function automatic logic same_line(input btb_upd_t a, input btb_upd_t b);
        return (a.idx == b.idx) && (a.tag == b.tag);
    endfunction

    // A younger packet for the same line wins on target/kind; mispredicts accumulate.
    function automatic btb_upd_t merge_upd(input btb_upd_t old_u, input btb_upd_t new_u);
        btb_upd_t u;
        u            = old_u;
        u.target     = new_u.target;
        u.uncond     = new_u.uncond;
        u.mispredict = old_u.mispredict | new_u.mispredict;
        return u;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Counted update queue: up to WIDTH pushes per cycle, one pop, and a rewrite
// port for the youngest entry.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int QDEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         push_en,
    input  logic [$clog2(WIDTH+1)-1:0]   push_n,
    input  btb_upd_t [WIDTH-1:0]         push_data,
    input  logic                         tail_wr,
    input  btb_upd_t                     tail_data,
    input  logic                         pop,
    output btb_upd_t                     head,
    output btb_upd_t                     tail,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH+1);

    btb_upd_t         mem_r [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] push_cnt_s;
    logic             do_pop_s;

    // Effective push and pop amounts for this cycle
    always_comb begin
        push_cnt_s = push_en ? CNT_W'(push_n) : CNT_W'(0);
        do_pop_s   = pop && (count_r != CNT_W'(0));
    end

    // Storage, pointers and occupancy; the count is kept separately so full and empty never alias
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (clear) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (push_en && (i < int'(push_n))) begin
                    mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[i];
                end
            end
            if (tail_wr) begin
                mem_r[wr_ptr_r - PTR_W'(1)] <= tail_data;
            end
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(do_pop_s);
            count_r  <= count_r + push_cnt_s - CNT_W'(do_pop_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign tail  = mem_r[wr_ptr_r - PTR_W'(1)];
    assign count = count_r;

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved branches and streams writes or a full
// clear walk to BTB storage. Define BTB_UPD_COALESCE_EN to merge same-line packets.
module btb_update_ctrl #(
    parameter int WIDTH    = `WIDTH,
    parameter int QDEPTH   = 8,
    parameter int BTB_SIZE = btb_pkg::BTB_SIZE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              rob_valid,
    input  logic [WIDTH-1:0][31:0]        rob_pc,
    input  logic [WIDTH-1:0][31:0]        rob_target,
    input  logic [WIDTH-1:0]              rob_uncond,
    input  logic [WIDTH-1:0]              rob_mispredict,
    output logic                          rob_ready,
    input  logic                          flush_req,
    output logic                          upd_valid,
    input  logic                          upd_ready,
    output logic                          upd_clear,
    output logic [btb_pkg::IDX_W-1:0]     upd_idx,
    output logic [btb_pkg::TAG_W-1:0]     upd_tag,
    output logic [btb_pkg::TGT_W-1:0]     upd_target,
    output logic                          upd_uncond,
    output logic                          upd_mispredict,
    output logic                          busy,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    import btb_pkg::btb_upd_t;
    import btb_pkg::btb_state_t;
    import btb_pkg::ST_RUN;
    import btb_pkg::ST_CLEAR;
    import btb_pkg::IDX_W;
    import btb_pkg::TAG_W;
    import btb_pkg::TGT_W;
    import btb_pkg::make_upd;
`ifdef BTB_UPD_COALESCE_EN
    import btb_pkg::same_line;
    import btb_pkg::merge_upd;
`endif

    localparam int CNT_W  = $clog2(QDEPTH+1);
    localparam int PUSH_W = $clog2(WIDTH+1);

    btb_state_t           state_r;
    logic [IDX_W-1:0]     clr_idx_r;
    btb_upd_t             head_s;
    btb_upd_t             tail_s;
    btb_upd_t             tail_new_s;
    btb_upd_t             pkt_s;
    btb_upd_t [WIDTH-1:0] lane_s;
    logic [PUSH_W-1:0]    lane_n_s;
    logic                 tail_wr_s;
    logic [CNT_W-1:0]     count_s;
    int                   req_n_s;
    logic                 ready_s;
    logic                 push_en_s;
    logic                 pop_s;

    // Admission uses the raw slot count so acceptance never depends on merge outcome
    always_comb begin
        req_n_s = 0;
        for (int i = 0; i < WIDTH; i++) begin
            req_n_s = req_n_s + int'(rob_valid[i]);
        end
        ready_s   = (state_r == ST_RUN) && ((QDEPTH - int'(count_s)) >= req_n_s);
        push_en_s = ready_s && !flush_req;
        pop_s     = (state_r == ST_RUN) && (count_s != CNT_W'(0)) && upd_ready && !flush_req;
    end

    // Pack valid slots into consecutive lanes in slot order
    always_comb begin
        lane_s     = '0;
        lane_n_s   = PUSH_W'(0);
        tail_wr_s  = 1'b0;
        tail_new_s = tail_s;
        pkt_s      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pkt_s = make_upd(rob_pc[i], rob_target[i], rob_uncond[i], rob_mispredict[i]);
            if (rob_valid[i]) begin
`ifdef BTB_UPD_COALESCE_EN
                // The queued tail is only touched when it is not the head, keeping upd_* stable
                if ((lane_n_s != PUSH_W'(0)) && same_line(lane_s[lane_n_s - PUSH_W'(1)], pkt_s)) begin
                    lane_s[lane_n_s - PUSH_W'(1)] = merge_upd(lane_s[lane_n_s - PUSH_W'(1)], pkt_s);
                end else if ((lane_n_s == PUSH_W'(0)) && (count_s >= CNT_W'(2)) && same_line(tail_new_s, pkt_s)) begin
                    tail_new_s = merge_upd(tail_new_s, pkt_s);
                    tail_wr_s  = 1'b1;
                end else begin
                    lane_s[lane_n_s] = pkt_s;
                    lane_n_s         = lane_n_s + PUSH_W'(1);
                end
`else
                lane_s[lane_n_s] = pkt_s;
                lane_n_s         = lane_n_s + PUSH_W'(1);
`endif
            end else begin
                lane_n_s = lane_n_s;
            end
        end
    end

    btb_upd_fifo #(
        .WIDTH  (WIDTH),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (flush_req),
        .push_en   (push_en_s),
        .push_n    (lane_n_s),
        .push_data (lane_s),
        .tail_wr   (tail_wr_s && push_en_s),
        .tail_data (tail_new_s),
        .pop       (pop_s),
        .head      (head_s),
        .tail      (tail_s),
        .count     (count_s)
    );

    // RUN/CLEAR sequencing and the clear walk counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_RUN;
            clr_idx_r <= IDX_W'(0);
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (flush_req) begin
                        state_r   <= ST_CLEAR;
                        clr_idx_r <= IDX_W'(0);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    if (flush_req) begin
                        clr_idx_r <= IDX_W'(0);
                    end else if (upd_ready) begin
                        if (clr_idx_r == IDX_W'(BTB_SIZE - 1)) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_CLEAR;
                        end
                        clr_idx_r <= clr_idx_r + IDX_W'(1);
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                default: begin
                    state_r   <= ST_RUN;
                    clr_idx_r <= IDX_W'(0);
                end
            endcase
        end
    end

    // Write-port view: clear walk, queue head, or idle zeros
    always_comb begin
        if (state_r == ST_CLEAR) begin
            upd_valid      = 1'b1;
            upd_clear      = 1'b1;
            upd_idx        = clr_idx_r;
            upd_tag        = TAG_W'(0);
            upd_target     = TGT_W'(0);
            upd_uncond     = 1'b0;
            upd_mispredict = 1'b0;
        end else if (count_s != CNT_W'(0)) begin
            upd_valid      = 1'b1;
            upd_clear      = 1'b0;
            upd_idx        = head_s.idx;
            upd_tag        = head_s.tag;
            upd_target     = head_s.target;
            upd_uncond     = head_s.uncond;
            upd_mispredict = head_s.mispredict;
        end else begin
            upd_valid      = 1'b0;
            upd_clear      = 1'b0;
            upd_idx        = IDX_W'(0);
            upd_tag        = TAG_W'(0);
            upd_target     = TGT_W'(0);
            upd_uncond     = 1'b0;
            upd_mispredict = 1'b0;
        end
    end

    assign rob_ready = ready_s;
    assign busy      = (state_r == ST_CLEAR);
    assign q_count   = count_s;

endmodule
